// File: rtl/aes_word1_rom_2r_if.sv
// Read-port bundle for the AES word1 round-key ROM: two independent address/enable/data ports.
interface aes_word1_rom_2r_if #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned AddressWidth = 9
);
  logic [AddressWidth-1:0] address0;
  logic                    ce0;
  logic [DataWidth-1:0]    q0;
  logic [AddressWidth-1:0] address1;
  logic                    ce1;
  logic [DataWidth-1:0]    q1;

  modport master (
    output address0, ce0, address1, ce1,
    input  q0, q1
  );

  modport slave (
    input  address0, ce0, address1, ce1,
    output q0, q1
  );
endinterface

// File: rtl/aes_word1_rom_2r.sv
// Dual-read-port synchronous ROM holding the AES AddRoundKey word1 byte table (4 x 120, row-major).
// Define WORD1_ROM_OUT_REG_EN to add a second output register stage per port (2-cycle latency).
module aes_word1_rom_2r #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned AddressRange = 480,
  parameter int unsigned AddressWidth = 9,
  parameter string       INIT_FILE    = ""
) (
  input logic               clk,
  input logic               reset,
  aes_word1_rom_2r_if.slave bus
);

  function automatic logic [DataWidth-1:0] default_word(input int unsigned a);
    logic [7:0] b;
    b = 8'(a % 256) ^ ((a >= 256) ? 8'hFF : 8'h00);
    return DataWidth'(b);
  endfunction

  logic [DataWidth-1:0] mem [AddressRange];

  for (genvar i = 0; i < AddressRange; i++) begin : g_word
    assign mem[i] = default_word(i);
  end

  // Out-of-range addresses read as zero rather than indexing past the table.
  logic [DataWidth-1:0] rd0, rd1;

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (32'(bus.address0) < AddressRange) rd0 = mem[bus.address0];
    if (32'(bus.address1) < AddressRange) rd1 = mem[bus.address1];
  end

  logic [DataWidth-1:0] q0_q = '0;
  logic [DataWidth-1:0] q1_q = '0;

`ifdef WORD1_ROM_OUT_REG_EN
  logic [DataWidth-1:0] s1_0_q = '0;
  logic [DataWidth-1:0] s1_1_q = '0;
  logic                 ce0_dly_q = 1'b0;
  logic                 ce1_dly_q = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_0_q    <= '0;
      s1_1_q    <= '0;
      ce0_dly_q <= 1'b0;
      ce1_dly_q <= 1'b0;
      q0_q      <= '0;
      q1_q      <= '0;
    end else begin
      ce0_dly_q <= bus.ce0;
      ce1_dly_q <= bus.ce1;
      if (bus.ce0)   s1_0_q <= rd0;
      if (bus.ce1)   s1_1_q <= rd1;
      if (ce0_dly_q) q0_q   <= s1_0_q;
      if (ce1_dly_q) q1_q   <= s1_1_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      q0_q <= '0;
      q1_q <= '0;
    end else begin
      if (bus.ce0) q0_q <= rd0;
      if (bus.ce1) q1_q <= rd1;
    end
  end
`endif

  assign bus.q0 = q0_q;
  assign bus.q1 = q1_q;

endmodule

// File: tb/tb_aes_word1_rom_2r.sv
// Directed bench for aes_word1_rom_2r with a per-port scoreboard of expected outputs.
module tb_aes_word1_rom_2r;

`ifdef WORD1_ROM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk;
  logic reset;

  aes_word1_rom_2r_if #(.DataWidth(8), .AddressWidth(9)) bus ();

  aes_word1_rom_2r #(
    .DataWidth   (8),
    .AddressRange(480),
    .AddressWidth(9),
    .INIT_FILE   ("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  int         cyc;
  int         checks;
  int         errors;
  logic [7:0] last0;
  logic [7:0] last1;

  function automatic logic [7:0] ref_word(input int unsigned a);
    if (a >= 480) return 8'h00;
    return (a >= 256) ? (8'(a - 256) ^ 8'hFF) : 8'(a);
  endfunction

  task automatic compare_due();
    exp_t e;
    while (sb0.size() > 0 && sb0[0].due <= cyc) begin
      e = sb0.pop_front();
      checks++;
      assert (bus.q0 === e.val)
      else begin
        errors++;
        $error("FAIL %s q0: got %h expected %h", e.tag, bus.q0, e.val);
      end
    end
    while (sb1.size() > 0 && sb1[0].due <= cyc) begin
      e = sb1.pop_front();
      checks++;
      assert (bus.q1 === e.val)
      else begin
        errors++;
        $error("FAIL %s q1: got %h expected %h", e.tag, bus.q1, e.val);
      end
    end
  endtask

  // Drive one cycle of stimulus, record what the outputs must become, then check after the edge.
  task automatic step(input logic [8:0] a0, input logic c0, input logic [8:0] a1,
                      input logic c1, input logic rst_n, input string tag);
    bus.address0 = a0;
    bus.ce0      = c0;
    bus.address1 = a1;
    bus.ce1      = c1;
    reset        = rst_n;
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      last0 = 8'h00;
      last1 = 8'h00;
      sb0.push_back('{due: cyc + 1, val: 8'h00, tag: tag});
      sb1.push_back('{due: cyc + 1, val: 8'h00, tag: tag});
    end else begin
      if (c0) last0 = ref_word(32'(a0));
      if (c1) last1 = ref_word(32'(a1));
      sb0.push_back('{due: cyc + Lat, val: last0, tag: tag});
      sb1.push_back('{due: cyc + Lat, val: last1, tag: tag});
    end
    @(posedge clk);
    cyc++;
    #1;
    compare_due();
  endtask

  initial begin
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    last0        = 8'h00;
    last1        = 8'h00;
    reset        = 1'b1;
    bus.address0 = '0;
    bus.address1 = '0;
    bus.ce0      = 1'b0;
    bus.ce1      = 1'b0;
    #1;

    checks++;
    assert (bus.q0 === 8'h00)
    else begin
      errors++;
      $error("FAIL powerup q0: got %h expected %h", bus.q0, 8'h00);
    end
    checks++;
    assert (bus.q1 === 8'h00)
    else begin
      errors++;
      $error("FAIL powerup q1: got %h expected %h", bus.q1, 8'h00);
    end

    // Reset holds both outputs at zero despite active reads.
    step(9'd5, 1'b1, 9'd300, 1'b1, 1'b0, "reset_a");
    step(9'd5, 1'b1, 9'd300, 1'b1, 1'b0, "reset_b");
    step(9'd5, 1'b1, 9'd300, 1'b1, 1'b1, "release");

    // Back-to-back reads on port 0 while port 1 idles and holds.
    step(9'd0,   1'b1, 9'd0, 1'b0, 1'b1, "pipe_0");
    step(9'd1,   1'b1, 9'd0, 1'b0, 1'b1, "pipe_1");
    step(9'd479, 1'b1, 9'd0, 1'b0, 1'b1, "pipe_479");

    // Hold on port 1 with a changing address.
    step(9'd479, 1'b0, 9'd255, 1'b1, 1'b1, "hold_rd");
    step(9'd479, 1'b0, 9'd7,   1'b0, 1'b1, "hold_1");
    step(9'd479, 1'b0, 9'd7,   1'b0, 1'b1, "hold_2");
    step(9'd479, 1'b0, 9'd7,   1'b0, 1'b1, "hold_3");
    step(9'd479, 1'b0, 9'd7,   1'b1, 1'b1, "hold_rel");

    // Out-of-range reads, then the first word of the inverted half.
    step(9'd480, 1'b1, 9'd511, 1'b1, 1'b1, "oor");
    step(9'd256, 1'b1, 9'd256, 1'b1, 1'b1, "addr_256");

    // Same address on both ports, plus a few scattered rows.
    step(9'd360, 1'b1, 9'd360, 1'b1, 1'b1, "same_360");
    step(9'd119, 1'b1, 9'd120, 1'b1, 1'b1, "row_edge");
    step(9'd239, 1'b1, 9'd359, 1'b1, 1'b1, "row_edge2");

    // Reset in the middle of a stream discards in-flight reads.
    step(9'd10,  1'b1, 9'd400, 1'b1, 1'b1, "stream_a");
    step(9'd20,  1'b1, 9'd410, 1'b1, 1'b1, "stream_b");
    step(9'd30,  1'b1, 9'd420, 1'b1, 1'b0, "stream_rst");
    step(9'd40,  1'b1, 9'd430, 1'b1, 1'b1, "stream_c");
    step(9'd50,  1'b1, 9'd440, 1'b1, 1'b1, "stream_d");

    // Drain the pipeline.
    step(9'd0, 1'b0, 9'd0, 1'b0, 1'b1, "drain_a");
    step(9'd0, 1'b0, 9'd0, 1'b0, 1'b1, "drain_b");
    step(9'd0, 1'b0, 9'd0, 1'b0, 1'b1, "drain_c");

    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sb0.size(), sb1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
